pwm_audio_out: RTL and testbench



---
 rtl/pwm_audio_out.sv | 129 ++++++++++++
 tb/tb_pwm_audio_out.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_out.sv
// pwm_audio_out
// PWM audio output stage. Unsigned samples arrive over a valid/ready
// handshake into a one-entry buffer. Each sample becomes the duty cycle
// of one fixed-length PWM period. The duty cycle changes only at a period
// boundary, so a period never shows a glitch. If a boundary arrives with
// no sample buffered, the previous duty repeats and a sticky underrun flag
// is set.
module pwm_audio_out #(
  parameter int WIDTH    = 8,   // sample width; period is 2^WIDTH counter steps
  parameter int PRESCALE = 1    // clock cycles per counter step, 1..256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             clear_underrun,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

  // The prescaler needs at least one bit, even when it never counts.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIDSCALE   = {1'b1, {(WIDTH-1){1'b0}}};

  // Registered state and its next-state values
  logic [PW-1:0]    presc_q,        presc_d;
  logic [WIDTH-1:0] cnt_q,          cnt_d;
  logic [WIDTH-1:0] active_q,       active_d;
  logic [WIDTH-1:0] pend_q,         pend_d;
  logic             pend_valid_q,   pend_valid_d;
  logic             pwm_q,          pwm_d;
  logic             period_start_q, period_start_d;
  logic             underrun_q,     underrun_d;

  // Per-cycle events
  logic step;    // the PWM counter advances on this cycle
  logic wrap;    // the last step of a period; the next duty loads here
  logic accept;  // a sample transfers into the buffer on this cycle

  // The prescaler is held while disabled, so no step and no wrap can occur.
  assign step = ena && (presc_q == PRESC_LAST);
  assign wrap = step && (cnt_q == CNT_LAST);

  // Ready depends only on registered state and ena, never on sample_valid,
  // so upstream can form valid from ready without a combinational loop.
  assign sample_ready = ena && !pend_valid_q;
  assign accept       = sample_valid && sample_ready;

  // Next-state logic for the step counters, buffer, duty and flags
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    presc_d        = presc_q;
    cnt_d          = cnt_q;
    active_d       = active_q;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    underrun_d     = underrun_q;
    period_start_d = wrap;
    // Compare on the current count and duty; ena low forces the pin low.
    pwm_d          = ena && (cnt_q < active_q);

    if (ena) begin
      presc_d = step ? '0 : presc_q + 1'b1;
    end

    if (step) begin
      cnt_d = cnt_q + 1'b1;   // wraps naturally from all-ones to zero
    end

    // Period boundary: take the buffered sample, or repeat the last duty.
    if (wrap) begin
      if (pend_valid_q) begin
        active_d     = pend_q;
        pend_valid_d = 1'b0;
      end
    end

    // Accept only happens with the buffer empty, so it never collides with
    // the load above. An accept on the wrap cycle fills the buffer for the
    // following boundary.
    if (accept) begin
      pend_d       = sample_in;
      pend_valid_d = 1'b1;
    end

    // Set has priority over clear when both occur in the same cycle.
    if (wrap && !pend_valid_q) begin
      underrun_d = 1'b1;
    end else if (clear_underrun) begin
      underrun_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      active_q       <= MIDSCALE;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge value of the others regardless of statement order.
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out
// Bench for pwm_audio_out. A PRESCALE=1 instance is compared on every
// cycle against a reference model built from counts, a sample queue and
// the period arithmetic. A PRESCALE=3 instance shares clock, reset and
// enable and is checked for period length and high time.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       clear_underrun;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;

  logic [7:0] sample_in3;
  logic       sample_valid3;
  logic       ready3;
  logic       pwm3;
  logic       ps3;
  logic       underrun3;

  pwm_audio_out #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .clear_underrun (clear_underrun),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .underrun       (underrun)
  );

  pwm_audio_out #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .sample_in      (sample_in3),
    .sample_valid   (sample_valid3),
    .sample_ready   (ready3),
    .clear_underrun (clear_underrun),
    .pwm_out        (pwm3),
    .period_start   (ps3),
    .underrun       (underrun3)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: enabled-cycle count gives the position in the period,
  // a queue holds at most one waiting sample.
  int m_en;
  int m_active;
  int m_pend[$];
  bit m_underrun;
  bit m_pwm;
  bit m_ps;
  int m_ended;      // duty of the period that just finished
  bit m_last_acc;

  // Observation counters
  int hi, cyc, last_hi, last_cyc;
  bit ps_flag;
  int hi3, cyc3, last_hi3, last_cyc3, ps3_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en       = 0;
    m_active   = 128;
    m_pend.delete();
    m_underrun = 1'b0;
    m_pwm      = 1'b0;
    m_ps       = 1'b0;
    m_ended    = 0;
    m_last_acc = 1'b0;
    hi = 0; cyc = 0; last_hi = 0; last_cyc = 0; ps_flag = 1'b0;
    hi3 = 0; cyc3 = 0; last_hi3 = 0; last_cyc3 = 0; ps3_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  pos;
    bit  rdy, acc, wrp, set_ur;
    pos    = m_en % 256;
    rdy    = ena && (m_pend.size() == 0);
    acc    = sample_valid && rdy;
    wrp    = ena && (pos == 255);
    set_ur = wrp && (m_pend.size() == 0);
    m_pwm  = ena && (pos < m_active);
    m_ps   = wrp;
    if (wrp) begin
      m_ended = m_active;
      if (m_pend.size() != 0) m_active = m_pend.pop_front();
    end
    if (set_ur)              m_underrun = 1'b1;
    else if (clear_underrun) m_underrun = 1'b0;
    if (acc) m_pend.push_back(int'(sample_in));
    if (ena) m_en++;
    m_last_acc = acc;
  endtask

  // One clock: update the model, then compare all outputs 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("ready",        sample_ready, ena && (m_pend.size() == 0));
    check("pwm_out",      pwm_out,      m_pwm);
    check("period_start", period_start, m_ps);
    check("underrun",     underrun,     m_underrun);
    cyc++;
    hi += int'(pwm_out);
    if (period_start === 1'b1) begin
      check("period_high", hi, m_ended);
      last_hi  = hi;
      last_cyc = cyc;
      hi       = 0;
      cyc      = 0;
      ps_flag  = 1'b1;
    end
    cyc3++;
    hi3 += int'(pwm3);
    if (ps3 === 1'b1) begin
      last_hi3  = hi3;
      last_cyc3 = cyc3;
      hi3       = 0;
      cyc3      = 0;
      ps3_cnt++;
    end
  endtask

  // Run until the next period_start; report the finished period.
  task automatic run_period(output int h, output int c);
    ps_flag = 1'b0;
    for (int i = 0; i < 2000 && !ps_flag; i++) tick();
    check("period_seen", ps_flag, 1);
    h = last_hi;
    c = last_cyc;
  endtask

  // Present a sample and hold it until it transfers.
  task automatic push(input logic [7:0] val, output int waits);
    bit got;
    bit r;
    got   = 1'b0;
    waits = 0;
    sample_in    = val;
    sample_valid = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      r = (sample_ready === 1'b1);
      tick();
      if (r) got = 1'b1;
      else   waits++;
    end
    sample_valid = 1'b0;
    check("push_accepted", got, 1);
  endtask

  // Assert reset between edges, check outputs at once, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pwm",          pwm_out,      0);
    check("rst_period_start", period_start, 0);
    check("rst_underrun",     underrun,     0);
    check("rst_ready",        sample_ready, ena);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, c, w, n;
    bit got;

    ena = 1'b1; sample_in = 8'h00; sample_valid = 1'b0; clear_underrun = 1'b0;
    sample_in3 = 8'h00; sample_valid3 = 1'b0;
    rst_n = 1'b0;
    model_reset();

    // Reset, no samples: midscale periods, underrun after first wrap
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_ready",    sample_ready, 1);
    check("in_reset_pwm",      pwm_out,      0);
    check("in_reset_underrun", underrun,     0);
    @(negedge clk);
    rst_n = 1'b1;
    run_period(h, c);
    check("first_period_high", h, 128);
    check("first_period_len",  c, 256);
    check("first_wrap_underrun", underrun, 1);
    run_period(h, c);
    check("second_period_len", c, 256);

    // Push 0x40 ten cycles into a period
    repeat (10) tick();
    push(8'h40, w);
    check("push40_ready_low", sample_ready, 0);
    run_period(h, c);
    check("before40_high", h, 128);
    run_period(h, c);
    check("duty40_high", h, 64);

    // Extremes in consecutive periods
    push(8'h00, w);
    run_period(h, c);
    push(8'hFF, w);
    run_period(h, c);
    check("duty00_high", h, 0);
    run_period(h, c);
    check("dutyFF_high", h, 255);
    check("dutyFF_len",  c, 256);

    // Backpressure: the second sample waits for the buffer to drain
    push(8'h20, w);
    push(8'h90, w);
    check("bp_waited", w > 0, 1);
    run_period(h, c);
    check("duty20_high", h, 32);
    run_period(h, c);
    check("duty90_high", h, 144);

    // ena dropped at cnt=100 for 50 cycles
    push(8'hC8, w);
    run_period(h, c);
    for (int i = 0; i < 300 && (m_en % 256) != 100; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("ena_off_pwm", pwm_out,      0);
      check("ena_off_ps",  period_start, 0);
    end
    ena = 1'b1;
    ps_flag = 1'b0;
    n = 0;
    for (int i = 0; i < 1000 && !ps_flag; i++) begin
      tick();
      n++;
    end
    check("resume_steps", n, 156);
    check("resume_high",  last_hi, 200);

    // Underrun clear, then set and clear in the same cycle
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    check("underrun_cleared", underrun, 0);
    for (int i = 0; i < 300 && (m_en % 256) != 255; i++) tick();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    check("underrun_set_wins", underrun, 1);
    check("set_wins_ps", period_start, 1);

    // Reset mid-period with a pending sample
    push(8'h10, w);
    repeat (5) tick();
    check("pre_reset_pwm",   pwm_out,      1);
    check("pre_reset_ready", sample_ready, 0);
    do_reset();
    run_period(h, c);
    check("post_reset_high", h, 128);
    check("post_reset_len",  c, 256);

    // Randomized traffic, enable and clear against the model
    for (int i = 0; i < 4000; i++) begin
      ena            = ($urandom_range(0, 15) != 0);
      clear_underrun = ($urandom_range(0, 63) == 0);
      if (!sample_valid || m_last_acc) begin
        sample_valid = ($urandom_range(0, 199) == 0);
        sample_in    = 8'($urandom);
      end
      tick();
    end
    ena = 1'b1; clear_underrun = 1'b0; sample_valid = 1'b0;

    // PRESCALE=3: 768-cycle periods, duty 0x40 gives 192 high cycles
    @(negedge clk);
    do_reset();
    sample_in3    = 8'h40;
    sample_valid3 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (ready3 === 1'b1) got = 1'b1;
      tick();
    end
    sample_valid3 = 1'b0;
    check("p3_push_accepted", got, 1);
    for (int i = 0; i < 3000 && ps3_cnt < 1; i++) tick();
    check("p3_first_high", last_hi3,  384);
    check("p3_first_len",  last_cyc3, 768);
    check("p3_no_underrun", underrun3, 0);
    for (int i = 0; i < 3000 && ps3_cnt < 2; i++) tick();
    check("p3_duty40_high", last_hi3,  192);
    check("p3_duty40_len",  last_cyc3, 768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
